// File: rtl/bsg_decode_one_hot_buffered.sv
// Binary index to one-hot decoder behind a 2-entry valid/ready -> valid/yumi buffer.
// Out-of-range indices store an all-zero word with an error flag and bump a saturating counter.
module bsg_decode_one_hot_buffered #(
    parameter int width_p     = 31,
    parameter bit lo_to_hi_p  = 1'b1,
    parameter int err_cnt_w_p = 8,
    localparam int aw_lp = (width_p == 1) ? 1 : $clog2(width_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    input  logic [aw_lp-1:0]       addr_i,
    output logic                   ready_o,
    output logic                   v_o,
    output logic [width_p-1:0]     o,
    output logic                   err_o,
    input  logic                   yumi_i,
    output logic [err_cnt_w_p-1:0] err_cnt_o
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    localparam logic [aw_lp:0] width_lp = (aw_lp + 1)'(width_p);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_ready;
    logic                     r_wptr;
    logic                     r_rptr;
    logic [width_p-1:0]       r_data [2];
    logic [1:0]               r_err;
    logic [err_cnt_w_p-1:0]   r_err_cnt;

    logic                     w_enq;
    logic                     w_deq;
    logic                     w_in_range;
    logic [width_p-1:0]       w_hot;

    assign w_enq      = v_i & r_ready;
    assign w_deq      = yumi_i & v_o;
    assign w_in_range = ({1'b0, addr_i} < width_lp);

    always_comb begin
        w_hot = '0;
        for (int i = 0; i < width_p; i++) begin
            if (w_in_range &&
                addr_i == aw_lp'(lo_to_hi_p ? i : width_p - 1 - i))
                w_hot[i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= S_EMPTY;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != S_FULL);
        end
    end

    // Enqueue in FULL cannot happen: r_ready is already low there.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_enq) w_state_nxt = S_ONE;
            S_ONE: begin
                if (w_enq && !w_deq)
                    w_state_nxt = S_FULL;
                else if (!w_enq && w_deq)
                    w_state_nxt = S_EMPTY;
            end
            S_FULL:  if (w_deq) w_state_nxt = S_ONE;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_data[0] <= '0;
            r_data[1] <= '0;
            r_err     <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_enq) begin
                r_data[r_wptr] <= w_hot;
                r_err[r_wptr]  <= ~w_in_range;
                r_wptr         <= ~r_wptr;
                if (!w_in_range && r_err_cnt != '1)
                    r_err_cnt <= r_err_cnt + err_cnt_w_p'(1);
            end
            if (w_deq)
                r_rptr <= ~r_rptr;
        end
    end

    assign v_o       = (r_state != S_EMPTY);
    assign ready_o   = r_ready;
    assign o         = v_o ? r_data[r_rptr] : '0;
    assign err_o     = v_o & r_err[r_rptr];
    assign err_cnt_o = r_err_cnt;

    a_yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o
    );

endmodule

// File: tb/tb_bsg_decode_one_hot_buffered.sv
// Randomized bench for bsg_decode_one_hot_buffered with a queue-based reference model.
// Two instances share stimulus: one decodes lo-to-hi, the other hi-to-lo.
module tb_bsg_decode_one_hot_buffered;

    localparam int W  = 31;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          v = 1'b0;
    logic          yumi = 1'b0;
    logic [AW-1:0] addr = '0;

    logic          ready_o, v_o, err_o;
    logic [W-1:0]  o;
    logic [7:0]    err_cnt_o;
    logic          ready_hi, v_hi, err_hi;
    logic [W-1:0]  o_hi;
    logic [7:0]    cnt_hi;

    bsg_decode_one_hot_buffered #(
        .width_p(W), .lo_to_hi_p(1'b1), .err_cnt_w_p(8)
    ) u_dut (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v), .addr_i(addr),
        .ready_o(ready_o), .v_o(v_o), .o(o), .err_o(err_o),
        .yumi_i(yumi), .err_cnt_o(err_cnt_o)
    );

    bsg_decode_one_hot_buffered #(
        .width_p(W), .lo_to_hi_p(1'b0), .err_cnt_w_p(8)
    ) u_dut_hi (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v), .addr_i(addr),
        .ready_o(ready_hi), .v_o(v_hi), .o(o_hi), .err_o(err_hi),
        .yumi_i(yumi), .err_cnt_o(cnt_hi)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int q[$];
    int m_errcnt = 0;
    bit m_ready  = 1'b0;

    function automatic logic [W-1:0] exp_lo(int k);
        logic [W-1:0] one;
        one = 1;
        if (k >= W) return '0;
        return one << k;
    endfunction

    function automatic logic [W-1:0] exp_hi(int k);
        logic [W-1:0] one;
        one = 1;
        if (k >= W) return '0;
        return one << (W - 1 - k);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs();
        chk("v_o", 64'(v_o), 64'(q.size() > 0));
        chk("v_hi", 64'(v_hi), 64'(q.size() > 0));
        chk("ready_o", 64'(ready_o), 64'(m_ready));
        chk("ready_hi", 64'(ready_hi), 64'(m_ready));
        chk("err_cnt", 64'(err_cnt_o), 64'(m_errcnt));
        chk("err_cnt_hi", 64'(cnt_hi), 64'(m_errcnt));
        if (q.size() > 0) begin
            chk("o", 64'(o), 64'(exp_lo(q[0])));
            chk("o_hi", 64'(o_hi), 64'(exp_hi(q[0])));
            chk("err_o", 64'(err_o), 64'(q[0] >= W));
            chk("err_hi", 64'(err_hi), 64'(q[0] >= W));
        end else begin
            chk("o_idle", 64'(o), 64'(0));
            chk("err_idle", 64'(err_o), 64'(0));
        end
    endtask

    // Called between negedge and posedge; returns at the following negedge.
    task automatic cycle(input bit iv, input int ia, input bit iy,
                         output bit acc);
        v    = iv;
        addr = AW'(ia);
        yumi = iy && (q.size() > 0);
        @(posedge clk);
        acc = 1'b0;
        if (rst_n) begin
            acc = iv && m_ready;
            if (yumi) void'(q.pop_front());
            if (acc) begin
                q.push_back(ia);
                if (ia >= W && m_errcnt < 255) m_errcnt++;
            end
            m_ready = (q.size() < 2);
        end
        #1 check_outs();
        @(negedge clk);
        v    = 1'b0;
        yumi = 1'b0;
    endtask

    task automatic drain();
        bit a;
        for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b1, a);
    endtask

    initial begin
        bit a;
        bit got12;

        @(negedge clk);
        #1 check_outs();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b0, 0, 1'b0, a);
        chk("ready_after_rst", 64'(ready_o), 64'(1));

        for (int k = 0; k < W; k++) begin
            cycle(1'b1, k, 1'b1, a);
            chk("t1_acc", 64'(a), 64'(1));
            chk("t1_o", 64'(o), 64'(exp_lo(k)));
        end
        drain();

        cycle(1'b1, 0, 1'b0, a);
        chk("t2_hi0", 64'(o_hi), 64'(31'h4000_0000));
        cycle(1'b1, 30, 1'b1, a);
        chk("t2_hi30", 64'(o_hi), 64'(31'h1));
        drain();

        cycle(1'b1, 31, 1'b0, a);
        chk("t3_err_o", 64'(err_o), 64'(1));
        chk("t3_err_zero", 64'(o), 64'(0));
        cycle(1'b1, 0, 1'b1, a);
        chk("t3_ok_o", 64'(o), 64'(1));
        chk("t3_cnt1", 64'(err_cnt_o), 64'(1));
        drain();
        for (int i = 0; i < 300; i++) cycle(1'b1, 31, 1'b1, a);
        drain();
        chk("t3_sat", 64'(err_cnt_o), 64'(255));

        cycle(1'b1, 5, 1'b0, a);
        chk("t4_acc5", 64'(a), 64'(1));
        cycle(1'b1, 9, 1'b0, a);
        chk("t4_acc9", 64'(a), 64'(1));
        cycle(1'b1, 12, 1'b0, a);
        chk("t4_rej12", 64'(a), 64'(0));
        chk("t4_full", 64'(ready_o), 64'(0));
        got12 = 1'b0;
        for (int i = 0; i < 6 && !got12; i++) begin
            cycle(1'b1, 12, 1'b1, a);
            if (a) got12 = 1'b1;
        end
        chk("t4_acc12", 64'(got12), 64'(1));
        chk("t4_head12", 64'(o), 64'(exp_lo(12)));
        drain();

        cycle(1'b1, 3, 1'b0, a);
        chk("t5_head3", 64'(o), 64'(31'h8));
        cycle(1'b1, 7, 1'b1, a);
        chk("t5_head7", 64'(o), 64'(31'h80));
        chk("t5_one_rdy", 64'(ready_o), 64'(1));
        drain();
        for (int k = 0; k < 10; k++)
            cycle(1'b1, k + 10, 1'($urandom_range(0, 1)), a);
        drain();

        for (int i = 0; i < 500; i++)
            cycle(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)),
                  1'($urandom_range(0, 2) != 0), a);
        drain();

        cycle(1'b1, 1, 1'b0, a);
        cycle(1'b1, 2, 1'b0, a);
        chk("t6_full", 64'(ready_o), 64'(0));
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        m_errcnt = 0;
        m_ready  = 1'b0;
        chk("t6_v", 64'(v_o), 64'(0));
        chk("t6_o", 64'(o), 64'(0));
        chk("t6_cnt", 64'(err_cnt_o), 64'(0));
        chk("t6_rdy", 64'(ready_o), 64'(0));
        cycle(1'b0, 0, 1'b0, a);
        cycle(1'b1, 6, 1'b0, a);
        chk("t6_noacc", 64'(a), 64'(0));
        #2 rst_n = 1'b1;
        cycle(1'b0, 0, 1'b0, a);
        chk("t6_rdy_rel", 64'(ready_o), 64'(1));
        cycle(1'b1, 4, 1'b0, a);
        chk("t6_post_o", 64'(o), 64'(31'h10));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
